wb_mailbox_monitor: RTL and testbench
=====================================

Name: wb_mailbox_monitor

Overview:
Passive Wishbone snoop block that decodes writes to a parametrised bank of mailbox channels and turns them into run status and console traffic. Channel 0 is the exit/status mailbox (pass/fail codes). Channels 1..NUM_CHANNELS-1 are console byte streams, buffered in a shared FIFO. A cycle watchdog flags a timeout. It sits beside the SoC bus, in the sim harness or on FPGA, driving LEDs or a UART bridge.

Parameters:
BASE_ADDR, 32'h0000_F000, word-aligned byte address of channel 0; channel n is at BASE_ADDR + 4*n
NUM_CHANNELS, 4, total mailbox channels (2..16); channel 0 is status, the rest are console
PASS_CODE, 8'h01, status byte meaning pass
FAIL_CODE, 8'hFF, status byte meaning fail
FIFO_DEPTH, 16, console FIFO entries; power of two, 2..256
MAX_CYCLES, 200000, watchdog limit in clk cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wb_cyc_i  in  1  snooped bus cycle
wb_stb_i  in  1  snooped strobe
wb_we_i  in  1  snooped write enable
wb_ack_i  in  1  snooped slave ack; qualifies the beat
wb_adr_i  in  32  snooped byte address
wb_dat_i  in  32  snooped write data
wb_sel_i  in  4  snooped byte selects
con_valid  out  1  console FIFO head valid
con_ready  in  1  consumer accepts head
con_data  out  8  console byte at head
con_chan  out  4  source channel of head byte
done  out  1  sticky; run has terminated (pass, fail or timeout)
pass  out  1  sticky pass
fail  out  1  sticky fail
timeout  out  1  sticky watchdog expiry
exit_code  out  8  status byte that ended the run; 0 on timeout
cycle_count  out  32  cycles elapsed in RUN state
con_overflow  out  1  sticky; at least one console byte was dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; state RUN; cycle_count 0.
- Beat qualifier: wr_beat = cyc & stb & we & ack & sel[0]. One beat counts once; stalled cycles without ack are ignored.
- Address match: wb_adr_i[31:2] == (BASE_ADDR>>2) + n, for n < NUM_CHANNELS. Writes to other addresses are ignored.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and hold until reset.
  - In RUN, a ch0 beat with dat[7:0]==PASS_CODE goes to PASS on the next edge; exit_code=PASS_CODE; done=pass=1.
  - In RUN, a ch0 beat with dat[7:0]==FAIL_CODE goes to FAIL; exit_code=FAIL_CODE; done=fail=1.
  - Any other ch0 byte is ignored.
  - In RUN, when MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1, the next edge goes to TIMEOUT; done=timeout=1; exit_code=0.
  - If a status beat and watchdog expiry occur in the same cycle, the status beat wins.
- cycle_count increments every cycle in RUN and freezes in terminal states. It is 32-bit and wraps (watchdog only when MAX_CYCLES=0).
- Console push: a beat to ch n>=1 while in RUN pushes {n, dat[7:0]}. Console beats in terminal states are ignored. The FIFO keeps draining after done.
- FIFO is first-word-fall-through, registered. A push into an empty FIFO gives con_valid=1 on the next cycle.
- Pop occurs when con_valid & con_ready. con_data and con_chan hold stable while con_valid & !con_ready.
- Full: a push is accepted if not full, or if a pop happens in the same cycle. Otherwise the byte is dropped and con_overflow is set (sticky).
- Simultaneous push and pop on an empty FIFO: no pop occurs (valid is 0); the push is accepted.
- Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full is detected by MSBs differing and LSBs equal.

Optional Feature:
MBOX_CHAN_STATS_EN:
- Defined: adds output chan_writes [NUM_CHANNELS*16-1:0]. Each channel has a 16-bit saturating count of qualified beats (all states, including dropped console bytes). Counts reset to 0 and saturate at 16'hFFFF.
- Not defined: no port, no counters.

Test Plan:
- Reset, then 3 console beats to ch1 (0x48, 0x69, 0x0A), con_ready=1 -> bytes 0x48, 0x69, 0x0A out in order with con_chan=1; con_valid first high 1 cycle after first ack.
- ch0 write 0x0000_0001 with ack -> next edge done=pass=1, exit_code=0x01, cycle_count frozen; a later ch0 write of 0xFF leaves fail=0.
- ch0 write 0x0000_00FF with stb high 3 cycles and ack only on cycle 3 -> fail asserted exactly once, after the ack cycle; ch0 write of 0x42 beforehand has no effect.
- MAX_CYCLES=50, no writes -> timeout=done=1 at cycle_count==50, exit_code=0; a ch0 0x01 beat on cycle 49 -> pass instead, timeout=0.
- FIFO_DEPTH=4, con_ready=0, 6 beats to ch2 -> 4 held, con_overflow=1. Then con_ready=1 with a push in the same cycle while full -> accepted, no new drop.
- Async rst_n pulse mid-run with FIFO half full and pass=1 -> all outputs 0 immediately, FIFO empty, state RUN; with MBOX_CHAN_STATS_EN, chan_writes cleared.

Source files
------------

// File: rtl/wb_mailbox_monitor.sv
// Passive Wishbone mailbox snoop: status channel 0 ends the run (pass/fail),
// channels 1..NUM_CHANNELS-1 feed a shared console FIFO, a watchdog flags timeout.
// Optional: define MBOX_CHAN_STATS_EN to add per-channel saturating write counters.
module wb_mailbox_monitor #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter logic [7:0]  PASS_CODE    = 8'h01,
   parameter logic [7:0]  FAIL_CODE    = 8'hFF,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned MAX_CYCLES   = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_ack_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        con_valid,
   input  logic        con_ready,
   output logic [7:0]  con_data,
   output logic [3:0]  con_chan,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [7:0]  exit_code,
   output logic [31:0] cycle_count,
   output logic        con_overflow
`ifdef MBOX_CHAN_STATS_EN
   ,
   output logic [NUM_CHANNELS*16-1:0] chan_writes
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = 12;

   localparam logic        WD_EN   = (MAX_CYCLES != 0);
   localparam logic [31:0] WD_LAST = WD_EN ? 32'(MAX_CYCLES - 1) : 32'd0;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_PASS    = 2'd1;
   localparam logic [1:0] ST_FAIL    = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [31:0]   r_cycle_count;
   logic          r_done, r_pass, r_fail, r_timeout, r_overflow;
   logic [7:0]    r_exit_code;

   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic          r_con_valid;
   logic [7:0]    r_con_data;
   logic [3:0]    r_con_chan;

   logic [29:0]   w_word_off;
   logic          w_hit, w_beat, w_run, w_status, w_wd_expire;
   logic [3:0]    w_chan;
   logic          w_pop, w_full, w_push_req, w_push, w_drop;
   logic [PW-1:0] w_wr_nxt, w_rd_nxt;
   logic [EW-1:0] w_entry, w_head_nxt;
   logic          w_unused_ok;

   // Bus decode: qualified write beat and channel index relative to BASE_ADDR
   assign w_word_off  = wb_adr_i[31:2] - BASE_ADDR[31:2];
   assign w_hit       = (w_word_off < 30'(NUM_CHANNELS));
   assign w_chan      = w_word_off[3:0];
   assign w_beat      = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_i & wb_sel_i[0];
   assign w_run       = (r_state == ST_RUN);
   assign w_status    = w_beat & w_hit & (w_chan == 4'd0);
   assign w_wd_expire = WD_EN & (r_cycle_count == WD_LAST);
   assign w_unused_ok = &{1'b0, wb_dat_i[31:8], wb_sel_i[3:1], w_word_off[29:4]};

   // Next-state logic; a status beat takes priority over watchdog expiry
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_status && (wb_dat_i[7:0] == PASS_CODE))
               w_state_nxt = ST_PASS;
            else if (w_status && (wb_dat_i[7:0] == FAIL_CODE))
               w_state_nxt = ST_FAIL;
            else if (w_wd_expire)
               w_state_nxt = ST_TIMEOUT;
         end
         default: w_state_nxt = r_state;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // Sticky run result, captured on the single RUN -> terminal transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_timeout   <= 1'b0;
         r_exit_code <= 8'h00;
      end else if (w_run && (w_state_nxt != ST_RUN)) begin
         r_done      <= 1'b1;
         r_pass      <= (w_state_nxt == ST_PASS);
         r_fail      <= (w_state_nxt == ST_FAIL);
         r_timeout   <= (w_state_nxt == ST_TIMEOUT);
         r_exit_code <= (w_state_nxt == ST_PASS) ? PASS_CODE :
                        (w_state_nxt == ST_FAIL) ? FAIL_CODE : 8'h00;
      end
   end

   // Free-running cycle counter while in RUN, frozen once terminated
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_cycle_count <= 32'd0;
      else if (w_run) r_cycle_count <= r_cycle_count + 32'd1;
   end

   // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
   assign w_pop      = r_con_valid & con_ready;
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push_req = w_beat & w_hit & (w_chan != 4'd0) & w_run;
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & ~w_push;
   assign w_wr_nxt   = r_wr_ptr + PW'(w_push);
   assign w_rd_nxt   = r_rd_ptr + PW'(w_pop);
   assign w_entry    = {w_chan, wb_dat_i[7:0]};
   // New head is the byte being written when the FIFO ends up holding only that entry
   assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_entry
                                                          : r_mem[w_rd_nxt[AW-1:0]];

   // FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
   end

   // Pointers, registered head output and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_con_valid <= 1'b0;
         r_con_data  <= 8'h00;
         r_con_chan  <= 4'h0;
         r_overflow  <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_nxt;
         r_rd_ptr    <= w_rd_nxt;
         r_con_valid <= (w_wr_nxt != w_rd_nxt);
         if (w_wr_nxt != w_rd_nxt)
            {r_con_chan, r_con_data} <= w_head_nxt;
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   assign con_valid    = r_con_valid;
   assign con_data     = r_con_data;
   assign con_chan     = r_con_chan;
   assign done         = r_done;
   assign pass         = r_pass;
   assign fail         = r_fail;
   assign timeout      = r_timeout;
   assign exit_code    = r_exit_code;
   assign cycle_count  = r_cycle_count;
   assign con_overflow = r_overflow;

`ifdef MBOX_CHAN_STATS_EN
   logic [15:0] r_chan_writes [NUM_CHANNELS];

   // Per-channel saturating count of qualified beats, in every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < int'(NUM_CHANNELS); n++) r_chan_writes[n] <= 16'h0000;
      end else begin
         for (int n = 0; n < int'(NUM_CHANNELS); n++)
            if (w_beat && w_hit && (w_chan == 4'(n)) && (r_chan_writes[n] != 16'hFFFF))
               r_chan_writes[n] <= r_chan_writes[n] + 16'd1;
      end
   end

   for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_stats
      assign chan_writes[g*16 +: 16] = r_chan_writes[g];
   end
`endif

endmodule

// File: tb/tb_wb_mailbox_monitor.sv
// Self-checking bench for wb_mailbox_monitor: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_mailbox_monitor;

   localparam logic [31:0] BASE  = 32'h0000_F000;
   localparam int          N     = 4;
   localparam int          DEPTH = 4;
   localparam int          MAXC  = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0, wb_ack_i = 0;
   logic [31:0] wb_adr_i = 0, wb_dat_i = 0;
   logic [3:0]  wb_sel_i = 0;
   logic        con_ready = 0;
   logic        con_valid, done, pass, fail, timeout, con_overflow;
   logic [7:0]  con_data, exit_code;
   logic [3:0]  con_chan;
   logic [31:0] cycle_count;
`ifdef MBOX_CHAN_STATS_EN
   logic [N*16-1:0] chan_writes;
`endif

   wb_mailbox_monitor #(.BASE_ADDR(BASE), .NUM_CHANNELS(N), .PASS_CODE(8'h01),
                        .FAIL_CODE(8'hFF), .FIFO_DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_i(wb_ack_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data), .con_chan(con_chan),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout), .exit_code(exit_code),
      .cycle_count(cycle_count), .con_overflow(con_overflow)
`ifdef MBOX_CHAN_STATS_EN
      , .chan_writes(chan_writes)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ch_adr(input int n);
      return BASE + 32'(4 * n);
   endfunction

   task automatic set_idle();
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_ack_i = 0; wb_sel_i = 4'h0;
   endtask

   task automatic set_beat(input logic [31:0] adr, input logic [7:0] dat, input logic ack);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_ack_i = ack; wb_sel_i = 4'h1;
      wb_adr_i = adr; wb_dat_i = {24'hABCDE0, dat};
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   bit          m_done, m_pass, m_fail, m_to, m_ovf;
   logic [7:0]  m_exit;
   logic [31:0] m_cnt;
   logic [11:0] m_q[$];

   task automatic model_reset();
      m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0;
      m_exit = 8'h00; m_cnt = 32'd0; m_q.delete();
   endtask

   task automatic model_step();
      bit beat, running, pop, was_full;
      int ch;
      logic [29:0] word;
      beat = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_i & wb_sel_i[0];
      ch = -1;
      word = wb_adr_i[31:2];
      if (beat && word >= BASE[31:2] && (word - BASE[31:2]) < 30'(N))
         ch = int'(word - BASE[31:2]);
      running  = !m_done;
      pop      = (m_q.size() > 0) && con_ready;
      was_full = (m_q.size() == DEPTH);
      if (running) begin
         if (ch == 0 && wb_dat_i[7:0] == 8'h01) begin
            m_done = 1; m_pass = 1; m_exit = 8'h01;
         end else if (ch == 0 && wb_dat_i[7:0] == 8'hFF) begin
            m_done = 1; m_fail = 1; m_exit = 8'hFF;
         end else if (m_cnt == 32'(MAXC - 1)) begin
            m_done = 1; m_to = 1; m_exit = 8'h00;
         end
         m_cnt = m_cnt + 1;
      end
      if (pop) void'(m_q.pop_front());
      if (running && ch >= 1) begin
         if (!was_full || pop) m_q.push_back({4'(ch), wb_dat_i[7:0]});
         else                  m_ovf = 1;
      end
   endtask

   task automatic model_check();
      chk("rnd_valid", 32'(con_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("rnd_data", 32'(con_data), 32'(m_q[0][7:0]));
         chk("rnd_chan", 32'(con_chan), 32'(m_q[0][11:8]));
      end
      chk("rnd_done", 32'(done), 32'(m_done));
      chk("rnd_pass", 32'(pass), 32'(m_pass));
      chk("rnd_fail", 32'(fail), 32'(m_fail));
      chk("rnd_timeout", 32'(timeout), 32'(m_to));
      chk("rnd_exit", 32'(exit_code), 32'(m_exit));
      chk("rnd_count", cycle_count, m_cnt);
      chk("rnd_ovf", 32'(con_overflow), 32'(m_ovf));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      set_idle();
      con_ready = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        cyc, stb, ack, ready;
      logic [31:0] adr;
      logic [7:0]  dat;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [3:0]  exp_chan;
      logic        exp_done, exp_fail;
      logic [7:0]  exp_exit;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{1, 1, 1, 1, ch_adr(1), 8'h48, 1, 8'h48, 4'd1, 0, 0, 8'h00, 32'd1};
      vt[1] = '{1, 1, 1, 1, ch_adr(1), 8'h69, 1, 8'h69, 4'd1, 0, 0, 8'h00, 32'd2};
      vt[2] = '{1, 1, 1, 1, ch_adr(1), 8'h0A, 1, 8'h0A, 4'd1, 0, 0, 8'h00, 32'd3};
      vt[3] = '{0, 0, 0, 1, ch_adr(1), 8'h00, 0, 8'h00, 4'd0, 0, 0, 8'h00, 32'd4};
      vt[4] = '{1, 1, 1, 1, ch_adr(0), 8'h42, 0, 8'h00, 4'd0, 0, 0, 8'h00, 32'd5};
      vt[5] = '{1, 1, 0, 1, ch_adr(0), 8'hFF, 0, 8'h00, 4'd0, 0, 0, 8'h00, 32'd6};
      vt[6] = '{1, 1, 0, 1, ch_adr(0), 8'hFF, 0, 8'h00, 4'd0, 0, 0, 8'h00, 32'd7};
      vt[7] = '{1, 1, 1, 1, ch_adr(0), 8'hFF, 0, 8'h00, 4'd0, 1, 1, 8'hFF, 32'd8};
      vt[8] = '{0, 0, 0, 1, ch_adr(0), 8'h00, 0, 8'h00, 4'd0, 1, 1, 8'hFF, 32'd8};

      // Reset state
      do_reset();
      chk("rst_valid", 32'(con_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_fail", 32'(fail), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_exit", 32'(exit_code), 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_ovf", 32'(con_overflow), 0);

      // Console stream, ignored status byte, stalled fail beat
      for (int i = 0; i < 9; i++) begin
         wb_cyc_i = vt[i].cyc; wb_stb_i = vt[i].stb; wb_we_i = 1; wb_ack_i = vt[i].ack;
         wb_sel_i = 4'h1; wb_adr_i = vt[i].adr; wb_dat_i = {24'h0, vt[i].dat};
         con_ready = vt[i].ready;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(con_valid), 32'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d_data", i), 32'(con_data), 32'(vt[i].exp_data));
            chk($sformatf("vec%0d_chan", i), 32'(con_chan), 32'(vt[i].exp_chan));
         end
         chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].exp_done));
         chk($sformatf("vec%0d_fail", i), 32'(fail), 32'(vt[i].exp_fail));
         chk($sformatf("vec%0d_exit", i), 32'(exit_code), 32'(vt[i].exp_exit));
         chk($sformatf("vec%0d_count", i), cycle_count, vt[i].exp_cnt);
      end

      // Pass then later fail code is ignored; count frozen
      do_reset();
      set_beat(ch_adr(0), 8'h01, 1); tick();
      chk("pass_pass", 32'(pass), 1);
      chk("pass_done", 32'(done), 1);
      chk("pass_exit", 32'(exit_code), 8'h01);
      chk("pass_count", cycle_count, 1);
      set_idle(); repeat (3) tick();
      chk("pass_frozen", cycle_count, 1);
      set_beat(ch_adr(0), 8'hFF, 1); tick(); set_idle();
      chk("pass_nofail", 32'(fail), 0);
      chk("pass_exit2", 32'(exit_code), 8'h01);

      // Watchdog expiry
      do_reset();
      repeat (49) tick();
      chk("wd_cnt49", cycle_count, 49);
      chk("wd_notyet", 32'(done), 0);
      tick();
      chk("wd_timeout", 32'(timeout), 1);
      chk("wd_done", 32'(done), 1);
      chk("wd_exit", 32'(exit_code), 0);
      chk("wd_cnt50", cycle_count, 50);
      tick();
      chk("wd_frozen", cycle_count, 50);

      // Status beat beats watchdog in the same cycle
      do_reset();
      repeat (49) tick();
      set_beat(ch_adr(0), 8'h01, 1); tick(); set_idle();
      chk("race_pass", 32'(pass), 1);
      chk("race_timeout", 32'(timeout), 0);
      chk("race_exit", 32'(exit_code), 8'h01);

      // Overflow and push-while-full-with-pop
      do_reset();
      con_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         set_beat(ch_adr(2), 8'(i), 1); tick();
         if (i == 4) chk("full_noovf", 32'(con_overflow), 0);
      end
      chk("ovf_set", 32'(con_overflow), 1);
      chk("ovf_head", 32'(con_data), 8'h01);
      chk("ovf_chan", 32'(con_chan), 4'd2);
      con_ready = 1;
      set_beat(ch_adr(2), 8'h07, 1); tick(); set_idle();
      chk("fullpop_head", 32'(con_data), 8'h02);
      tick(); chk("drain_3", 32'(con_data), 8'h03);
      tick(); chk("drain_4", 32'(con_data), 8'h04);
      tick(); chk("drain_7", 32'(con_data), 8'h07);
      chk("drain_7v", 32'(con_valid), 1);
      tick(); chk("drain_empty", 32'(con_valid), 0);

      // Asynchronous reset mid-run
      do_reset();
      con_ready = 0;
      set_beat(ch_adr(3), 8'h11, 1); tick();
      set_beat(ch_adr(3), 8'h22, 1); tick();
      set_beat(ch_adr(0), 8'h01, 1); tick(); set_idle();
      chk("ar_pre_pass", 32'(pass), 1);
      chk("ar_pre_valid", 32'(con_valid), 1);
`ifdef MBOX_CHAN_STATS_EN
      chk("ar_pre_stats3", 32'(chan_writes[3*16 +: 16]), 2);
`endif
      #2 rst_n = 0;
      #1;
      chk("ar_valid", 32'(con_valid), 0);
      chk("ar_pass", 32'(pass), 0);
      chk("ar_done", 32'(done), 0);
      chk("ar_exit", 32'(exit_code), 0);
      chk("ar_count", cycle_count, 0);
`ifdef MBOX_CHAN_STATS_EN
      chk("ar_stats", chan_writes[31:0], 0);
`endif
      @(negedge clk); rst_n = 1; model_reset();
      tick();
      chk("ar_post_valid", 32'(con_valid), 0);
      chk("ar_post_count", cycle_count, 1);

      // Randomized traffic against the model
      for (int run = 0; run < 6; run++) begin
         do_reset();
         for (int c = 0; c < 70; c++) begin
            int r;
            wb_cyc_i = ($urandom_range(0, 4) != 0);
            wb_stb_i = ($urandom_range(0, 4) != 0);
            wb_we_i  = ($urandom_range(0, 4) != 0);
            wb_ack_i = ($urandom_range(0, 3) != 0);
            wb_sel_i = 4'($urandom);
            con_ready = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 40));
            wb_dat_i = $urandom;
            if (r == 0) begin
               wb_adr_i = ch_adr(0);
               case ($urandom_range(0, 2))
                  0: wb_dat_i[7:0] = 8'h01;
                  1: wb_dat_i[7:0] = 8'hFF;
                  default: ;
               endcase
            end else if (r < 34) wb_adr_i = ch_adr((r % 3) + 1);
            else if (r < 36)     wb_adr_i = ch_adr(N);
            else if (r < 38)     wb_adr_i = BASE - 32'd4;
            else                 wb_adr_i = $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
            model_check();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
